// File: rtl/core_fetch.sv
// core_fetch -- fetch-stage PC owner and instruction buffer.
//
// Holds the architectural fetch PC and issues in-order requests to
// instruction memory over a valid/ready handshake. Each accepted request
// reserves a buffer slot tagged with its PC. Returned words fill the slots
// in order and are presented to ID from the head of a circular FIFO. A
// redirect loads a new PC and clears the buffer. Responses that were still
// in flight at the redirect are counted and then discarded.
//
// Parameters
//   RESET_PC   fetch PC loaded on reset
//   BUF_DEPTH  buffer slots = max outstanding requests (power of 2, >= 2)
//   INSN_W     instruction width
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   redirect, redirect_pc             flush + new fetch PC (low 2 bits ignored)
//   imem_req_valid/ready/addr         fetch request handshake
//   imem_resp_valid/data              in-order response, no backpressure
//   if_valid, if_insn, if_pc, if_pc4  head of the buffer presented to ID
//   id_ready                          ID consumes the head
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters
//   perf_redirects (redirect cycles) and perf_dropped (discarded responses).

module core_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2,
  parameter int          INSN_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INSN_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [INSN_W-1:0] if_insn,
  output logic [63:0]       if_pc,
  output logic [63:0]       if_pc4,
  input  logic              id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [63:0]    pc, pc_nxt, pc_addr;
  logic [AW-1:0]  head, tail, fill;
  logic [CW-1:0]  res_cnt;   // slots reserved (pending + filled)
  logic [CW-1:0]  pend_cnt;  // slots reserved but not yet filled
  logic [CW-1:0]  drop_cnt, drop_nxt;
  logic [BUF_DEPTH-1:0] filled;

  logic [63:0]       slot_pc   [BUF_DEPTH];
  logic [INSN_W-1:0] slot_insn [BUF_DEPTH];

  logic head_filled, pop, credit, req_valid, accept, keep, resp_stray;

  assign pc_addr     = pc & ~64'h3;
  assign head_filled = filled[head];

  // A redirect wins over a same-cycle pop and response.
  assign pop        = head_filled & id_ready & ~redirect;
  assign credit     = (res_cnt < CW'(BUF_DEPTH)) | pop;
  assign req_valid  = (state == RUN) & credit & ~redirect;
  assign accept     = req_valid & imem_req_ready;
  assign keep       = imem_resp_valid & (state == RUN) & ~redirect & (pend_cnt != '0);
  assign resp_stray = imem_resp_valid &
                      ((state == BOOT) | ((state == RUN) & (pend_cnt == '0)));

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    pc_nxt    = pc;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          if (imem_resp_valid && (pend_cnt != '0)) drop_nxt = pend_cnt - CW'(1);
          else                                     drop_nxt = pend_cnt;
          if (drop_nxt != '0) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) begin
          drop_nxt = drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (redirect)    pc_nxt = redirect_pc & ~64'h3;
    else if (accept) pc_nxt = pc + 64'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      res_cnt  <= '0;
      pend_cnt <= '0;
      filled   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop_cnt <= drop_nxt;
      if (redirect) begin
        head     <= '0;
        tail     <= '0;
        fill     <= '0;
        res_cnt  <= '0;
        pend_cnt <= '0;
        filled   <= '0;
      end else begin
        if (pop) begin
          filled[head] <= 1'b0;
          head         <= head + AW'(1);
        end
        if (keep) begin
          filled[fill] <= 1'b1;
          fill         <= fill + AW'(1);
        end
        if (accept) tail <= tail + AW'(1);
        res_cnt  <= res_cnt + CW'(accept) - CW'(pop);
        pend_cnt <= pend_cnt + CW'(accept) - CW'(keep);
      end
    end
  end

  // Slot payload: written only alongside the control that marks it live.
  always_ff @(posedge clk) begin
    if (accept) slot_pc[tail]   <= pc_addr;
    if (keep)   slot_insn[fill] <= imem_resp_data;
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_addr;
  assign if_valid       = head_filled;
  assign if_insn        = head_filled ? slot_insn[head] : '0;
  assign if_pc          = head_filled ? slot_pc[head]   : '0;
  assign if_pc4         = if_pc + 64'd4;

`ifdef FETCH_PERF_CNT_EN
  logic drop;

  assign drop = imem_resp_valid &
                ((state == DRAIN) | ((state == RUN) & redirect & (pend_cnt != '0)));

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_redirects <= '0;
      perf_dropped   <= '0;
    end else begin
      perf_redirects <= sat_inc(perf_redirects, redirect);
      perf_dropped   <= sat_inc(perf_dropped, drop);
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is ignored by the logic above.
  assert property (@(posedge clk) disable iff (!reset_n) !resp_stray);
`endif

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch -- self-checking bench for core_fetch.
// Drives a latency-configurable in-order memory and a randomised ID/redirect
// stream; expected outputs come from a queue-based reference model.
// Optional macro FETCH_PERF_CNT_EN enables the perf counter checks.

module tb_core_fetch;

  localparam logic [63:0] RPC   = 64'h1000;
  localparam int          DEPTH = 2;
  localparam int          M_BOOT = 0, M_RUN = 1, M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_insn;
  logic [63:0] if_pc;
  logic [63:0] if_pc4;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_dropped;
`endif

  core_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH), .INSN_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_insn(if_insn),
    .if_pc(if_pc), .if_pc4(if_pc4), .id_ready(id_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_redirects(perf_redirects), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory environment ----------------
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  logic        dut_acc;
  logic [63:0] dut_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'hC3A5_0F1E;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
  } ent_t;
  ent_t        m_rdy[$];   // returned words, oldest first
  logic [63:0] m_out[$];   // accepted requests still owed a response
  logic [63:0] m_pc;
  int          m_mode, m_drop;
  int          m_perf_r, m_perf_d;
  logic        exp_req_valid, exp_if_valid;
  logic [63:0] exp_addr, exp_if_pc;
  logic [31:0] exp_if_insn;

  function automatic void model_reset();
    m_rdy.delete(); m_out.delete();
    m_pc = RPC; m_mode = M_BOOT; m_drop = 0; m_perf_r = 0; m_perf_d = 0;
  endfunction

  function automatic void model_eval();
    int occ;
    occ = m_out.size() + m_rdy.size();
    exp_if_valid  = (m_rdy.size() > 0);
    exp_if_pc     = exp_if_valid ? m_rdy[0].pc : 64'h0;
    exp_if_insn   = exp_if_valid ? m_rdy[0].insn : 32'h0;
    exp_addr      = m_pc;
    exp_req_valid = (m_mode == M_RUN) && (occ < DEPTH || (exp_if_valid && id_ready)) && !redirect;
  endfunction

  function automatic void model_update();
    int d;
    logic [63:0] p;
    logic acc, pop;
    model_eval();
    acc = exp_req_valid && imem_req_ready;
    pop = exp_if_valid && id_ready;
    if (redirect) m_perf_r++;
    case (m_mode)
      M_BOOT: begin
        if (redirect) m_pc = redirect_pc & ~64'h3;
        m_mode = M_RUN;
      end
      M_RUN: begin
        if (redirect) begin
          d = m_out.size();
          if (imem_resp_valid && d > 0) begin d--; m_perf_d++; end
          m_out.delete(); m_rdy.delete();
          m_pc = redirect_pc & ~64'h3;
          if (d > 0) begin m_drop = d; m_mode = M_DRAIN; end
        end else begin
          if (pop) void'(m_rdy.pop_front());
          if (imem_resp_valid && m_out.size() > 0) begin
            p = m_out.pop_front();
            m_rdy.push_back('{p, mem_word(p)});
          end
          if (acc) begin m_out.push_back(m_pc); m_pc = m_pc + 64'd4; end
        end
      end
      default: begin
        if (redirect) m_pc = redirect_pc & ~64'h3;
        if (imem_resp_valid) begin
          m_drop--; m_perf_d++;
          if (m_drop == 0) m_mode = M_RUN;
        end
      end
    endcase
  endfunction

  function automatic bit idle();
    return m_mode == M_RUN && m_out.size() == 0 && m_rdy.size() == 0 &&
           mem_q.size() == 0 && !imem_resp_valid;
  endfunction

  // ---------------- cycle sequencing ----------------
  // Inputs change at posedge+1; outputs are sampled at the falling edge.
  task automatic sample_outputs();
    #4;
    model_eval();
    dut_acc  = imem_req_valid & imem_req_ready;
    dut_addr = imem_req_addr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_update();
    if (dut_acc) mem_q.push_back('{dut_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    cyc++;
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    mem_q.delete();
    model_reset();
    cyc = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic quiesce();
    int n = 0;
    imem_req_ready = 1'b0; id_ready = 1'b1; redirect = 1'b0;
    while (!idle() && n < 40) begin
      sample_outputs(); next_cycle(); n++;
    end
    checks++;
    if (!idle()) begin
      errors++; $display("FAIL quiesce: fetch unit not idle after %0d cycles", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    imem_req_ready = 1'b1; id_ready = 1'b1;
    assert_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b want 0", if_valid); end
    checks++; if (if_insn !== 32'h0) begin errors++; $display("FAIL rst_if_insn got %h want 0", if_insn); end
    checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
    release_reset();
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_req_valid got %b want 0", imem_req_valid); end
    next_cycle();
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      errors++; $display("FAIL first_req got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RPC);
    end
    next_cycle();
  endtask

  task automatic test_stream();
    logic [63:0] acc_a[$], pop_pc[$];
    logic [31:0] pop_insn[$];
    logic [63:0] got_a, got_pc;
    logic [31:0] got_i;
    assert_reset(); imem_req_ready = 1'b1; id_ready = 1'b1; lat_min = 1; lat_max = 1;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      sample_outputs();
      if (dut_acc) acc_a.push_back(dut_addr);
      if (if_valid) begin
        pop_pc.push_back(if_pc); pop_insn.push_back(if_insn);
        checks++; if (if_pc4 !== if_pc + 64'd4) begin errors++; $display("FAIL stream_pc4 got %h want %h", if_pc4, if_pc + 64'd4); end
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      got_a  = (i < acc_a.size())  ? acc_a[i]    : 64'hDEAD;
      got_pc = (i < pop_pc.size()) ? pop_pc[i]   : 64'hDEAD;
      got_i  = (i < pop_insn.size()) ? pop_insn[i] : 32'hDEAD;
      checks++; if (got_a !== RPC + 64'(4 * i)) begin errors++; $display("FAIL stream_req%0d got %h want %h", i, got_a, RPC + 64'(4 * i)); end
      checks++; if (got_pc !== RPC + 64'(4 * i)) begin errors++; $display("FAIL stream_pc%0d got %h want %h", i, got_pc, RPC + 64'(4 * i)); end
      checks++; if (got_i !== mem_word(RPC + 64'(4 * i))) begin errors++; $display("FAIL stream_insn%0d got %h want %h", i, got_i, mem_word(RPC + 64'(4 * i))); end
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    quiesce();
    imem_req_ready = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_outputs();
      checks++; if (imem_req_valid !== exp_req_valid) begin errors++; $display("FAIL bp_req_valid cyc %0d got %b want %b", i, imem_req_valid, exp_req_valid); end
      if (dut_acc) n_acc++;
      next_cycle();
    end
    checks++; if (n_acc != DEPTH) begin errors++; $display("FAIL bp_accepts got %0d want %0d", n_acc, DEPTH); end
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_stall got %b want 0", imem_req_valid); end
    next_cycle();
    id_ready = 1'b1;
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b1 || if_valid !== 1'b1) begin
      errors++; $display("FAIL bp_pop_reissue got req=%b ifv=%b want 1 1", imem_req_valid, if_valid);
    end
    next_cycle();
  endtask

  task automatic test_redirect_drain();
    quiesce();
    lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL drain_req0 got %b want 1", imem_req_valid); end
    next_cycle();
    sample_outputs(); next_cycle();
    redirect = 1'b1; redirect_pc = 64'h2000;
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_redir_req got %b want 0", imem_req_valid); end
    next_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample_outputs();
      checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        errors++; $display("FAIL drain_hold%0d got req=%b ifv=%b want 0 0", i, imem_req_valid, if_valid);
      end
      next_cycle();
    end
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000 || if_valid !== 1'b0) begin
      errors++; $display("FAIL drain_resume got req=%b a=%h ifv=%b want 1 2000 0", imem_req_valid, imem_req_addr, if_valid);
    end
    next_cycle();
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_redirect_collision();
    int n = 0;
    bit found = 0;
    quiesce();
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    while (!(if_valid && imem_resp_valid) && n < 20) begin
      sample_outputs(); next_cycle(); n++;
    end
    checks++; if (!(if_valid && imem_resp_valid)) begin errors++; $display("FAIL coll_setup got ifv=%b rv=%b want 1 1", if_valid, imem_resp_valid); end
    redirect = 1'b1; redirect_pc = 64'h3000;
    sample_outputs(); next_cycle();
    redirect = 1'b0;
    sample_outputs();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL coll_if_valid got %b want 0", if_valid); end
    for (int i = 0; i < 6 && !found; i++) begin
      if (imem_req_valid) begin
        found = 1;
        checks++; if (imem_req_addr !== 64'h3000) begin errors++; $display("FAIL coll_addr got %h want 3000", imem_req_addr); end
      end
      next_cycle(); sample_outputs();
    end
    checks++; if (!found) begin errors++; $display("FAIL coll_no_req got none want req at 3000"); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [63:0] acc_a[$], pop_pc[$], pop_pc4[$];
    logic [63:0] g0, g1, p0, q0;
    quiesce();
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    sample_outputs(); next_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_outputs();
      if (dut_acc) acc_a.push_back(dut_addr);
      if (if_valid) begin pop_pc.push_back(if_pc); pop_pc4.push_back(if_pc4); end
      next_cycle();
    end
    g0 = (acc_a.size() > 0) ? acc_a[0] : 64'hDEAD;
    g1 = (acc_a.size() > 1) ? acc_a[1] : 64'hDEAD;
    p0 = (pop_pc.size() > 0) ? pop_pc[0] : 64'hDEAD;
    q0 = (pop_pc4.size() > 0) ? pop_pc4[0] : 64'hDEAD;
    checks++; if (g0 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got %h want FFFFFFFFFFFFFFFC", g0); end
    checks++; if (g1 !== 64'h0) begin errors++; $display("FAIL wrap_req1 got %h want 0", g1); end
    checks++; if (p0 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_if_pc got %h want FFFFFFFFFFFFFFFC", p0); end
    checks++; if (q0 !== 64'h0) begin errors++; $display("FAIL wrap_if_pc4 got %h want 0", q0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      id_ready       = ($urandom_range(9, 0) < 7);
      redirect       = ($urandom_range(15, 0) == 0);
      redirect_pc    = ($urandom_range(7, 0) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                                                   : {32'($urandom), 32'($urandom)};
      lat_min = 1; lat_max = 3;
      sample_outputs();
      checks++; if (imem_req_valid !== exp_req_valid) begin errors++; $display("FAIL rnd_req_valid cyc %0d got %b want %b", cyc, imem_req_valid, exp_req_valid); end
      if (exp_req_valid) begin
        checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h want %h", cyc, imem_req_addr, exp_addr); end
      end
      checks++; if (if_valid !== exp_if_valid) begin errors++; $display("FAIL rnd_if_valid cyc %0d got %b want %b", cyc, if_valid, exp_if_valid); end
      if (exp_if_valid) begin
        checks++; if (if_pc !== exp_if_pc) begin errors++; $display("FAIL rnd_if_pc cyc %0d got %h want %h", cyc, if_pc, exp_if_pc); end
        checks++; if (if_insn !== exp_if_insn) begin errors++; $display("FAIL rnd_if_insn cyc %0d got %h want %h", cyc, if_insn, exp_if_insn); end
        checks++; if (if_pc4 !== exp_if_pc + 64'd4) begin errors++; $display("FAIL rnd_if_pc4 cyc %0d got %h want %h", cyc, if_pc4, exp_if_pc + 64'd4); end
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_redirects !== 32'(m_perf_r) || perf_dropped !== 32'(m_perf_d)) begin
        errors++; $display("FAIL rnd_perf cyc %0d got %0d/%0d want %0d/%0d", cyc, perf_redirects, perf_dropped, m_perf_r, m_perf_d);
      end
`endif
      next_cycle();
    end
    redirect = 1'b0;
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_reset_mid_drain();
    assert_reset(); imem_req_ready = 1'b0; id_ready = 1'b1; lat_min = 3; lat_max = 3;
    release_reset();
    sample_outputs(); next_cycle();                          // BOOT
    imem_req_ready = 1'b1; sample_outputs(); next_cycle();   // accept A
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h4000;
    sample_outputs(); next_cycle(); redirect = 1'b0;         // drop_cnt=1
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_drain1_req got %b want 0", imem_req_valid); end
    next_cycle();
    sample_outputs(); next_cycle();                          // A discarded
    redirect = 1'b1; redirect_pc = 64'h5000;
    sample_outputs(); next_cycle(); redirect = 1'b0;         // idle redirect
    imem_req_ready = 1'b1; sample_outputs();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h5000) begin
      errors++; $display("FAIL mid_req5000 got v=%b a=%h want 1 5000", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    sample_outputs(); next_cycle();                          // C, D accepted
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h6000;
    sample_outputs(); next_cycle(); redirect = 1'b0;         // drop_cnt=2
    sample_outputs(); next_cycle();                          // C discarded
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_in_drain got req=%b want 0", imem_req_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_redirects !== 32'd3) begin errors++; $display("FAIL perf_redirects got %0d want 3", perf_redirects); end
    checks++; if (perf_dropped !== 32'd2) begin errors++; $display("FAIL perf_dropped got %0d want 2", perf_dropped); end
`endif
    assert_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_insn !== 32'h0 || if_pc !== 64'h0) begin
      errors++; $display("FAIL mid_reset_outputs got req=%b ifv=%b insn=%h pc=%h want all 0", imem_req_valid, if_valid, if_insn, if_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_redirects !== 32'd0 || perf_dropped !== 32'd0) begin
      errors++; $display("FAIL mid_reset_perf got %0d/%0d want 0/0", perf_redirects, perf_dropped);
    end
`endif
    release_reset();
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1;
    sample_outputs(); next_cycle();
    sample_outputs();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      errors++; $display("FAIL post_reset_req got v=%b a=%h want 1 %h", imem_req_valid, imem_req_addr, RPC);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Fetch-stage PC owner and instruction buffer; consumer of the next-PC/flush redirect produced by the core's branch/exception logic.
- Holds the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PCs and presents them to ID.
- On redirect, flushes buffered words and discards stale in-flight responses.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset.
- BUF_DEPTH, 2, number of buffer slots; also the maximum number of outstanding requests. Power of 2, at least 2.
- INSN_W, 32, instruction width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- redirect  in  1  flush request from the next-PC logic.
- redirect_pc  in  64  new fetch PC; sampled when redirect=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  fetch address.
- imem_resp_valid  in  1  response word valid. In order, at least 1 cycle after acceptance, no backpressure.
- imem_resp_data  in  INSN_W  response word.
- if_valid  out  1  head buffer slot holds a returned word.
- if_insn  out  INSN_W  head instruction.
- if_pc  out  64  PC of the head instruction.
- if_pc4  out  64  if_pc+4.
- id_ready  in  1  ID consumes the head when if_valid=1.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; buffer empty; drop_cnt=0; FSM=BOOT.
  - imem_req_valid=0, if_valid=0, if_insn=0, if_pc=0.
- Buffer: circular FIFO of BUF_DEPTH slots {pc, insn, filled}.
  - A slot is reserved, with its pc, on request acceptance (imem_req_valid & imem_req_ready).
  - A kept response fills the oldest unfilled slot.
  - The head is presented when filled; pop on if_valid & id_ready.
  - Request may issue only if reserved slots < BUF_DEPTH, counting a same-cycle pop as freeing a slot.
- imem_req_addr = {pc[63:2],2'b00}. pc <= pc+4 on acceptance; 64-bit wrap, FFFF_FFFF_FFFF_FFFC+4 -> 0. Low 2 bits of redirect_pc are ignored.
- imem_req_valid = (FSM==RUN) & credit available & ~redirect. Once asserted it stays asserted with a stable address until accepted, unless redirect (the request is withdrawn).
- FSM:
  - BOOT: one cycle after reset release, then RUN.
  - RUN: on redirect, pc <= redirect_pc and all slots are cleared. drop_cnt <= number of reserved-but-unfilled slots, minus 1 if a response arrives that cycle. If the result is >0, go to DRAIN, else stay in RUN.
  - DRAIN: no requests issued. Each imem_resp_valid decrements drop_cnt and its data is discarded. At drop_cnt==1 with a response, go to RUN the next cycle. A redirect in DRAIN updates pc only; drop_cnt is unchanged.
- Simultaneous events:
  - Redirect beats a same-cycle pop; the pop is ignored and if_valid=0 next cycle.
  - Redirect beats a same-cycle response; the response is counted toward drop_cnt and discarded.
  - Redirect in BOOT loads pc and the FSM still enters RUN.
- A response with no outstanding request is a protocol error: ignored, with a simulation assertion.
- Latency: a redirect in cycle N, with nothing outstanding, gives imem_req_valid with the new address in cycle N+1. A response in cycle M gives if_valid in M+1.
- Reset mid-operation clears everything; in-flight memory responses after reset are the memory's responsibility, since memory shares reset_n.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_redirects [31:0] and perf_dropped [31:0], both 0 on reset and saturating at FFFF_FFFF.
  - perf_redirects: +1 per redirect cycle.
  - perf_dropped: +1 per discarded response.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Release reset, RESET_PC=0x1000, imem_req_ready=1, 1-cycle response latency, id_ready=1 -> requests 0x1000, 0x1004, 0x1008; if_pc/if_insn follow in order; if_pc4 = if_pc+4.
- id_ready=0 with the buffer filled -> exactly 2 requests are accepted, then imem_req_valid=0; id_ready=1 pops one and the next request issues the same cycle.
- Two requests outstanding, redirect_pc=0x2000 -> FSM enters DRAIN with drop_cnt=2. Both responses are discarded, if_valid stays 0, and the next request address is 0x2000.
- Redirect in the same cycle as a response and a pop -> the response is dropped, if_valid=0 next cycle, and pc=redirect_pc.
- redirect_pc=0xFFFF_FFFF_FFFF_FFFE -> request addr FFFF_FFFF_FFFF_FFFC, then 0x0.
- Assert reset_n=0 mid-DRAIN -> all outputs return to reset values asynchronously. With FETCH_PERF_CNT_EN, 3 redirects and 2 drops give perf_redirects=3 and perf_dropped=2 before that reset.
